dmem_port_arbiter: RTL and testbench

//  Shares the single-ported data memory between two cache requesters (M0 = D-cache, M1 = I-cache refill).

---
 rtl/dmem_port_arbiter_pkg.sv | 33 +++
 rtl/dmem_port_arbiter_if.sv | 43 ++++
 rtl/dmem_port_arbiter_rr2.sv | 41 ++++
 rtl/dmem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester data-memory port arbiter.
// The memory geometry lives here so the interface, the top and the picker all agree on widths.
package dmem_arb_pkg;

   localparam int ADDR_W    = 12;
   localparam int DATA_W    = 32;
   localparam int BE_W      = 4;
   localparam int BURST_LEN = 4;
   localparam int BEAT_W    = $clog2(BURST_LEN);

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   typedef enum logic {
      OWN_M0 = 1'b0,
      OWN_M1 = 1'b1
   } owner_t;

   typedef struct packed {
      logic              burst;
      logic              wen;
      logic [ADDR_W-1:0] addr;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] di;
   } req_attr_t;

   function automatic owner_t other_owner(input owner_t o);
      return (o == OWN_M0) ? OWN_M1 : OWN_M0;
   endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of both cache request ports plus the D_MEM pins.
// slave = arbiter view, master = environment (caches and memory) view.
interface dmem_port_arbiter_if;
   import dmem_arb_pkg::*;

   logic              M0_REQ,    M1_REQ;
   logic              M0_BURST,  M1_BURST;
   logic              M0_WEN,    M1_WEN;
   logic [ADDR_W-1:0] M0_ADDR,   M1_ADDR;
   logic [BE_W-1:0]   M0_BE,     M1_BE;
   logic [DATA_W-1:0] M0_DI,     M1_DI;
   logic              M0_GNT,    M1_GNT;
   logic              M0_RVALID, M1_RVALID;
   logic [BEAT_W-1:0] M0_BEAT,   M1_BEAT;
   logic              M0_DONE,   M1_DONE;
   logic [DATA_W-1:0] M0_DOUT,   M1_DOUT;

   logic              D_MEM_CSN;
   logic              D_MEM_WEN;
   logic [ADDR_W-1:0] D_MEM_ADDR;
   logic [BE_W-1:0]   D_MEM_BE;
   logic [DATA_W-1:0] D_MEM_DI;
   logic [DATA_W-1:0] D_MEM_DOUT;

   modport slave (
      input  M0_REQ, M0_BURST, M0_WEN, M0_ADDR, M0_BE, M0_DI,
      input  M1_REQ, M1_BURST, M1_WEN, M1_ADDR, M1_BE, M1_DI,
      output M0_GNT, M0_RVALID, M0_BEAT, M0_DONE, M0_DOUT,
      output M1_GNT, M1_RVALID, M1_BEAT, M1_DONE, M1_DOUT,
      output D_MEM_CSN, D_MEM_WEN, D_MEM_ADDR, D_MEM_BE, D_MEM_DI,
      input  D_MEM_DOUT
   );

   modport master (
      output M0_REQ, M0_BURST, M0_WEN, M0_ADDR, M0_BE, M0_DI,
      output M1_REQ, M1_BURST, M1_WEN, M1_ADDR, M1_BE, M1_DI,
      input  M0_GNT, M0_RVALID, M0_BEAT, M0_DONE, M0_DOUT,
      input  M1_GNT, M1_RVALID, M1_BEAT, M1_DONE, M1_DOUT,
      input  D_MEM_CSN, D_MEM_WEN, D_MEM_ADDR, D_MEM_BE, D_MEM_DI,
      output D_MEM_DOUT
   );

endinterface

// File: rtl/dmem_port_arbiter_rr2.sv
// Two-way round-robin picker; grants only while the arbiter is idle.
// The pointer moves away from the owner of a completing transaction.
module dmem_arb_rr2
   import dmem_arb_pkg::*;
(
   input  logic       CLK,
   input  logic       RSTn,
   input  logic [1:0] i_req,
   input  logic       i_en,
   input  logic       i_done,
   input  owner_t     i_done_owner,
   output logic [1:0] o_gnt
);

   owner_t r_ptr;
   owner_t w_ptr_eff;

   // A DONE and a new grant can share a cycle, so the tie-break already sees the moved pointer.
   assign w_ptr_eff = i_done ? other_owner(i_done_owner) : r_ptr;

   always_comb begin
      o_gnt = 2'b00;
      if (i_en) begin
         case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (w_ptr_eff == OWN_M0) ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_ptr <= OWN_M0;
      end else if (i_done) begin
         r_ptr <= other_owner(i_done_owner);
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-ported data memory between the D-cache (M0) and I-cache refill (M1).
// One transaction at a time: single access or BURST_LEN-word line read, read data returned with a beat tag.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
(
   input logic                CLK,
   input logic                RSTn,
   dmem_port_arbiter_if.slave io_bus
);

   state_t            r_state, w_state_nxt;
   owner_t            r_owner;
   logic [BEAT_W-1:0] r_beat, w_beat_nxt;
   req_attr_t         r_attr, w_req_sel;

   logic [1:0]        w_req, w_gnt;
   logic              w_idle, w_burst_rd, w_last_issue, w_done;
   logic              w_trk0, w_trk1;

   logic              r_trk_vld, r_trk_rd, r_trk_last;
   owner_t            r_trk_owner;
   logic [BEAT_W-1:0] r_trk_beat;

   assign w_req  = {io_bus.M1_REQ, io_bus.M0_REQ};
   assign w_idle = (r_state == IDLE);
   assign w_done = r_trk_vld & r_trk_last;

   dmem_arb_rr2 u_rr2 (
      .CLK          (CLK),
      .RSTn         (RSTn),
      .i_req        (w_req),
      .i_en         (w_idle),
      .i_done       (w_done),
      .i_done_owner (r_trk_owner),
      .o_gnt        (w_gnt)
   );

   always_comb begin
      w_req_sel = '{burst: io_bus.M0_BURST, wen: io_bus.M0_WEN, addr: io_bus.M0_ADDR,
                    be: io_bus.M0_BE, di: io_bus.M0_DI};
      if (w_gnt[1]) begin
         w_req_sel = '{burst: io_bus.M1_BURST, wen: io_bus.M1_WEN, addr: io_bus.M1_ADDR,
                       be: io_bus.M1_BE, di: io_bus.M1_DI};
      end
   end

   // Burst writes are unsupported: a burst with WEN=0 degrades to a plain single write.
   assign w_burst_rd   = r_attr.burst & r_attr.wen;
   assign w_last_issue = !w_burst_rd || (r_beat == BEAT_W'(BURST_LEN - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      case (r_state)
         IDLE: begin
            if (|w_gnt) begin
               w_state_nxt = ISSUE;
               w_beat_nxt  = '0;
            end
         end
         ISSUE: begin
            w_beat_nxt = r_beat + 1'b1;
            if (w_last_issue) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state <= IDLE;
         r_beat  <= '0;
         r_owner <= OWN_M0;
      end else begin
         r_state <= w_state_nxt;
         r_beat  <= w_beat_nxt;
         if (|w_gnt) begin
            r_owner <= w_gnt[1] ? OWN_M1 : OWN_M0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (|w_gnt) begin
         r_attr <= w_req_sel;
      end
   end

   // Return tracker: one entry per issue, seen the cycle the memory presents read data.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_trk_vld   <= 1'b0;
         r_trk_rd    <= 1'b0;
         r_trk_last  <= 1'b0;
         r_trk_owner <= OWN_M0;
         r_trk_beat  <= '0;
      end else if (r_state == ISSUE) begin
         r_trk_vld   <= 1'b1;
         r_trk_rd    <= r_attr.wen;
         r_trk_last  <= w_last_issue;
         r_trk_owner <= r_owner;
         r_trk_beat  <= w_burst_rd ? r_beat : '0;
      end else begin
         r_trk_vld   <= 1'b0;
      end
   end

   always_comb begin
      io_bus.D_MEM_CSN  = 1'b1;
      io_bus.D_MEM_WEN  = 1'b1;
      io_bus.D_MEM_ADDR = '0;
      io_bus.D_MEM_BE   = '0;
      io_bus.D_MEM_DI   = '0;
      if (r_state == ISSUE) begin
         io_bus.D_MEM_CSN = 1'b0;
         if (w_burst_rd) begin
            io_bus.D_MEM_ADDR = {r_attr.addr[ADDR_W-1:BEAT_W], r_beat};
            io_bus.D_MEM_BE   = '1;
         end else begin
            io_bus.D_MEM_WEN  = r_attr.wen;
            io_bus.D_MEM_ADDR = r_attr.addr;
            io_bus.D_MEM_BE   = r_attr.be;
            io_bus.D_MEM_DI   = r_attr.di;
         end
      end
   end

   assign w_trk0 = r_trk_vld & (r_trk_owner == OWN_M0);
   assign w_trk1 = r_trk_vld & (r_trk_owner == OWN_M1);

   assign io_bus.M0_GNT    = w_gnt[0];
   assign io_bus.M1_GNT    = w_gnt[1];
   assign io_bus.M0_RVALID = w_trk0 & r_trk_rd;
   assign io_bus.M1_RVALID = w_trk1 & r_trk_rd;
   assign io_bus.M0_DONE   = w_trk0 & r_trk_last;
   assign io_bus.M1_DONE   = w_trk1 & r_trk_last;
   assign io_bus.M0_BEAT   = w_trk0 ? r_trk_beat : '0;
   assign io_bus.M1_BEAT   = w_trk1 ? r_trk_beat : '0;
   assign io_bus.M0_DOUT   = io_bus.D_MEM_DOUT;
   assign io_bus.M1_DOUT   = io_bus.D_MEM_DOUT;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a synchronous single-port memory model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_dmem_port_arbiter;
   import dmem_arb_pkg::*;

   logic              CLK;
   logic              RSTn;
   int                n_checks;
   int                n_errors;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic              pre_we;
   logic [ADDR_W-1:0] pre_addr;
   logic [DATA_W-1:0] pre_data;

   dmem_port_arbiter_if bus ();

   dmem_port_arbiter dut (
      .CLK    (CLK),
      .RSTn   (RSTn),
      .io_bus (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) begin
      if (pre_we) begin
         mem[pre_addr] <= pre_data;
      end else if (!bus.D_MEM_CSN) begin
         if (bus.D_MEM_WEN) begin
            bus.D_MEM_DOUT <= mem[bus.D_MEM_ADDR];
         end else begin
            for (int b = 0; b < BE_W; b++) begin
               if (bus.D_MEM_BE[b]) mem[bus.D_MEM_ADDR][8*b +: 8] <= bus.D_MEM_DI[8*b +: 8];
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      pre_addr = a;
      pre_data = d;
      pre_we   = 1'b1;
      cyc();
      pre_we   = 1'b0;
   endtask

   task automatic drive(input int m, input logic rq, input logic burst, input logic wen,
                        input logic [ADDR_W-1:0] addr, input logic [BE_W-1:0] be,
                        input logic [DATA_W-1:0] di);
      if (m == 0) begin
         bus.M0_REQ = rq; bus.M0_BURST = burst; bus.M0_WEN = wen;
         bus.M0_ADDR = addr; bus.M0_BE = be; bus.M0_DI = di;
      end else begin
         bus.M1_REQ = rq; bus.M1_BURST = burst; bus.M1_WEN = wen;
         bus.M1_ADDR = addr; bus.M1_BE = be; bus.M1_DI = di;
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      pre_we   = 1'b0;
      pre_addr = '0;
      pre_data = '0;
      RSTn     = 1'b0;
      drive(0, 1'b0, 1'b0, 1'b1, '0, '0, '0);
      drive(1, 1'b0, 1'b0, 1'b1, '0, '0, '0);
      cyc();

      preload(12'h104, 32'hDEADBEEF);
      preload(12'h010, 32'hFFFFFFFF);
      for (int i = 0; i < 4; i++) preload(12'h0A4 + 12'(i), 32'hA0000000 + 32'(i));
      for (int i = 0; i < 4; i++) preload(12'h0A0 + 12'(i), 32'hB0000000 + 32'(i));

      // Reset state
      chk("rst_csn",  32'(bus.D_MEM_CSN), 32'd1);
      chk("rst_wen",  32'(bus.D_MEM_WEN), 32'd1);
      chk("rst_addr", 32'(bus.D_MEM_ADDR), 32'd0);
      chk("rst_be",   32'(bus.D_MEM_BE), 32'd0);
      chk("rst_di",   32'(bus.D_MEM_DI), 32'd0);
      chk("rst_flags", 32'({bus.M0_GNT, bus.M1_GNT, bus.M0_RVALID, bus.M1_RVALID,
                            bus.M0_DONE, bus.M1_DONE, bus.M0_BEAT, bus.M1_BEAT}), 32'd0);
      RSTn = 1'b1;
      cyc();

      // Contention right after reset: M0 first, M1 in M0's DONE cycle, next tie back to M0
      drive(0, 1'b1, 1'b0, 1'b1, 12'h104, 4'hF, '0);
      drive(1, 1'b1, 1'b0, 1'b1, 12'h0A4, 4'hF, '0);
      #1;
      chk("ct_c0_g0", 32'(bus.M0_GNT), 32'd1);
      chk("ct_c0_g1", 32'(bus.M1_GNT), 32'd0);
      cyc();
      bus.M0_REQ = 1'b0;
      #1;
      chk("ct_c1_g1",   32'(bus.M1_GNT), 32'd0);
      chk("ct_c1_addr", 32'(bus.D_MEM_ADDR), 32'h104);
      cyc();
      #1;
      chk("ct_c2_done0", 32'(bus.M0_DONE), 32'd1);
      chk("ct_c2_dout0", 32'(bus.M0_DOUT), 32'hDEADBEEF);
      chk("ct_c2_g1",    32'(bus.M1_GNT), 32'd1);
      chk("ct_c2_g0",    32'(bus.M0_GNT), 32'd0);
      cyc();
      bus.M1_REQ = 1'b0;
      #1;
      chk("ct_c3_addr", 32'(bus.D_MEM_ADDR), 32'h0A4);
      chk("ct_c3_csn",  32'(bus.D_MEM_CSN), 32'd0);
      cyc();
      bus.M0_REQ = 1'b1;
      bus.M1_REQ = 1'b1;
      #1;
      chk("ct_c4_done1", 32'(bus.M1_DONE), 32'd1);
      chk("ct_c4_rv1",   32'(bus.M1_RVALID), 32'd1);
      chk("ct_c4_dout1", 32'(bus.M1_DOUT), 32'hA0000000);
      chk("ct_c4_rv0",   32'(bus.M0_RVALID), 32'd0);
      chk("ct_c4_tie_g0", 32'(bus.M0_GNT), 32'd1);
      chk("ct_c4_tie_g1", 32'(bus.M1_GNT), 32'd0);
      cyc();
      bus.M0_REQ = 1'b0;
      bus.M1_REQ = 1'b0;
      #1;
      chk("ct_c5_addr", 32'(bus.D_MEM_ADDR), 32'h104);
      cyc();
      #1;
      chk("ct_c6_done0", 32'(bus.M0_DONE), 32'd1);
      chk("ct_c6_wd_g1", 32'(bus.M1_GNT), 32'd0);
      cyc();
      cyc();

      // Single read M0 at 0x104
      drive(0, 1'b1, 1'b0, 1'b1, 12'h104, 4'hF, '0);
      #1;
      chk("sr_c0_gnt", 32'(bus.M0_GNT), 32'd1);
      chk("sr_c0_csn", 32'(bus.D_MEM_CSN), 32'd1);
      cyc();
      bus.M0_REQ = 1'b0;
      #1;
      chk("sr_c1_csn",  32'(bus.D_MEM_CSN), 32'd0);
      chk("sr_c1_addr", 32'(bus.D_MEM_ADDR), 32'h104);
      chk("sr_c1_wen",  32'(bus.D_MEM_WEN), 32'd1);
      chk("sr_c1_rv",   32'(bus.M0_RVALID), 32'd0);
      cyc();
      #1;
      chk("sr_c2_rv",   32'(bus.M0_RVALID), 32'd1);
      chk("sr_c2_done", 32'(bus.M0_DONE), 32'd1);
      chk("sr_c2_beat", 32'(bus.M0_BEAT), 32'd0);
      chk("sr_c2_dout", 32'(bus.M0_DOUT), 32'hDEADBEEF);
      chk("sr_c2_csn",  32'(bus.D_MEM_CSN), 32'd1);
      cyc();
      #1;
      chk("sr_c3_done", 32'(bus.M0_DONE), 32'd0);
      cyc();

      // Burst read M1 at 0x0A6: wraps to line base 0x0A4, BE forced to all ones
      drive(1, 1'b1, 1'b1, 1'b1, 12'h0A6, 4'b0001, '0);
      #1;
      chk("br_c0_gnt", 32'(bus.M1_GNT), 32'd1);
      for (int k = 1; k <= 5; k++) begin
         cyc();
         bus.M1_REQ = 1'b0;
         #1;
         if (k <= 4) begin
            chk($sformatf("br_c%0d_addr", k), 32'(bus.D_MEM_ADDR), 32'h0A4 + 32'(k - 1));
            chk($sformatf("br_c%0d_be", k),   32'(bus.D_MEM_BE), 32'hF);
            chk($sformatf("br_c%0d_csn", k),  32'(bus.D_MEM_CSN), 32'd0);
         end else begin
            chk("br_c5_csn", 32'(bus.D_MEM_CSN), 32'd1);
         end
         if (k >= 2) begin
            chk($sformatf("br_c%0d_rv", k),   32'(bus.M1_RVALID), 32'd1);
            chk($sformatf("br_c%0d_beat", k), 32'(bus.M1_BEAT), 32'(k - 2));
            chk($sformatf("br_c%0d_dout", k), 32'(bus.M1_DOUT), 32'hA0000000 + 32'(k - 2));
         end else begin
            chk("br_c1_rv", 32'(bus.M1_RVALID), 32'd0);
         end
         chk($sformatf("br_c%0d_done", k), 32'(bus.M1_DONE), (k == 5) ? 32'd1 : 32'd0);
         chk($sformatf("br_c%0d_rv0", k),  32'(bus.M0_RVALID), 32'd0);
      end
      cyc();

      // Single write M0: 0x010 <- 0x12345678 with BE 0011
      drive(0, 1'b1, 1'b0, 1'b0, 12'h010, 4'b0011, 32'h12345678);
      #1;
      chk("wr_c0_gnt", 32'(bus.M0_GNT), 32'd1);
      cyc();
      bus.M0_REQ = 1'b0;
      #1;
      chk("wr_c1_csn",  32'(bus.D_MEM_CSN), 32'd0);
      chk("wr_c1_wen",  32'(bus.D_MEM_WEN), 32'd0);
      chk("wr_c1_be",   32'(bus.D_MEM_BE), 32'h3);
      chk("wr_c1_addr", 32'(bus.D_MEM_ADDR), 32'h010);
      chk("wr_c1_di",   32'(bus.D_MEM_DI), 32'h12345678);
      chk("wr_c1_rv",   32'(bus.M0_RVALID), 32'd0);
      cyc();
      #1;
      chk("wr_c2_done", 32'(bus.M0_DONE), 32'd1);
      chk("wr_c2_rv",   32'(bus.M0_RVALID), 32'd0);
      chk("wr_mem",     mem[12'h010], 32'hFFFF5678);
      cyc();
      #1;
      chk("wr_c3_rv", 32'(bus.M0_RVALID), 32'd0);

      // Burst flag with WEN=0 on M1: single write at the exact address, BE untouched
      drive(1, 1'b1, 1'b1, 1'b0, 12'h0A6, 4'b0100, 32'hCAFEF00D);
      #1;
      chk("bw_c0_gnt", 32'(bus.M1_GNT), 32'd1);
      cyc();
      bus.M1_REQ = 1'b0;
      #1;
      chk("bw_c1_addr", 32'(bus.D_MEM_ADDR), 32'h0A6);
      chk("bw_c1_be",   32'(bus.D_MEM_BE), 32'h4);
      chk("bw_c1_wen",  32'(bus.D_MEM_WEN), 32'd0);
      chk("bw_c1_di",   32'(bus.D_MEM_DI), 32'hCAFEF00D);
      cyc();
      #1;
      chk("bw_c2_done", 32'(bus.M1_DONE), 32'd1);
      chk("bw_c2_rv",   32'(bus.M1_RVALID), 32'd0);
      chk("bw_c2_csn",  32'(bus.D_MEM_CSN), 32'd1);
      chk("bw_mem",     mem[12'h0A6], 32'hA0FE0002);
      cyc();
      #1;
      chk("bw_c3_done", 32'(bus.M1_DONE), 32'd0);
      cyc();

      // Reset asserted mid-burst: everything drops at once, no DONE afterwards
      drive(0, 1'b1, 1'b1, 1'b1, 12'h0A1, 4'hF, '0);
      #1;
      chk("rb_c0_gnt", 32'(bus.M0_GNT), 32'd1);
      cyc();
      bus.M0_REQ = 1'b0;
      #1;
      chk("rb_c1_addr", 32'(bus.D_MEM_ADDR), 32'h0A0);
      cyc();
      #1;
      chk("rb_c2_rv",   32'(bus.M0_RVALID), 32'd1);
      chk("rb_c2_dout", 32'(bus.M0_DOUT), 32'hB0000000);
      cyc();
      RSTn = 1'b0;
      #1;
      chk("rb_rst_csn",  32'(bus.D_MEM_CSN), 32'd1);
      chk("rb_rst_addr", 32'(bus.D_MEM_ADDR), 32'd0);
      chk("rb_rst_be",   32'(bus.D_MEM_BE), 32'd0);
      chk("rb_rst_rv",   32'(bus.M0_RVALID), 32'd0);
      chk("rb_rst_beat", 32'(bus.M0_BEAT), 32'd0);
      chk("rb_rst_done", 32'(bus.M0_DONE), 32'd0);
      for (int k = 0; k < 2; k++) begin
         cyc();
         #1;
         chk($sformatf("rb_hold%0d_done", k), 32'(bus.M0_DONE), 32'd0);
         chk($sformatf("rb_hold%0d_csn", k),  32'(bus.D_MEM_CSN), 32'd1);
      end
      RSTn = 1'b1;
      cyc();
      #1;
      chk("rb_post_done", 32'(bus.M0_DONE), 32'd0);

      drive(1, 1'b1, 1'b0, 1'b1, 12'h104, 4'hF, '0);
      #1;
      chk("rb_m1_gnt", 32'(bus.M1_GNT), 32'd1);
      cyc();
      bus.M1_REQ = 1'b0;
      #1;
      chk("rb_m1_addr", 32'(bus.D_MEM_ADDR), 32'h104);
      cyc();
      #1;
      chk("rb_m1_done", 32'(bus.M1_DONE), 32'd1);
      chk("rb_m1_dout", 32'(bus.M1_DOUT), 32'hDEADBEEF);
      chk("rb_m0_done", 32'(bus.M0_DONE), 32'd0);
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
